ook_rx_deframer: RTL and testbench
==================================

// Module: ook_rx_deframer
// PURPOSE
//  Receive end of the OOK optical link: samples the asynchronous photodiode comparator
//  output, synchronises and glitch-filters it, detects the start bit, recovers 8 data bits
//  by mid-bit oversampling and presents each byte on a valid/ready holding register.
//  Sits between the analog front-end comparator pin and the receive packet logic.
//  Frame format (matches transmitter):
//    idle = 0 (light off), start = 1, D0..D7 LSB-first, stop = 0.
//    One bit = SAMPLES_PER_BIT clk cycles.
// PARAMETERS
//  SAMPLES_PER_BIT  64  clk cycles per bit. Even, >= 8. 64 @ 62.5 MHz = 976.5 kbit/s.
//  FILTER_TAPS       3  majority-filter length. Odd, 3 or 5.
// PORTS
//  clk        in   1  system clock, 62.5 MHz (16 ns)
//  rst        in   1  synchronous, active-high reset
//  ook_in     in   1  raw comparator output, asynchronous to clk
//  rx_ready   in   1  downstream accepts rx_data this cycle when rx_valid=1
//  rx_data    out  8  received byte, stable while rx_valid=1
//  rx_valid   out  1  holding register full
//  frame_err  out  1  1-cycle pulse: stop bit sampled as 1
//  overrun    out  1  1-cycle pulse: byte completed while holding register full and not popped
//  rx_busy    out  1  high in START/DATA/STOP states
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, counters 0, sync/filter registers 0.
//    Reset mid-frame discards the partial byte and any held byte.
//  - Front end: 2-FF synchroniser, then FILTER_TAPS-deep shift register.
//    line = majority of the taps. Input-to-line latency = 2 + (FILTER_TAPS+1)/2 cycles.
//    A high of < (FILTER_TAPS+1)/2 cycles never reaches line.
//  - Counter: cnt, width $clog2(SAMPLES_PER_BIT). Counts 0..SAMPLES_PER_BIT-1, wraps to 0.
//  - FSM:
//    IDLE  : line=1 -> START, cnt=0.
//    START : at cnt=SAMPLES_PER_BIT/2-1, sample line.
//              line=1 -> DATA, cnt=0, bit_idx=0.
//              line=0 -> IDLE (false start, no output).
//    DATA  : at each cnt=SAMPLES_PER_BIT-1, shift line into shreg[bit_idx], bit_idx++.
//              After bit 7 -> STOP.
//    STOP  : at cnt=SAMPLES_PER_BIT-1, sample line.
//              line=0 -> byte done, go to IDLE.
//              line=1 -> frame_err pulse, byte dropped, go to BREAK.
//    BREAK : wait for line=0, then IDLE. Prevents a stuck-on light from re-triggering.
//  - Byte done: next cycle rx_data<=shreg, rx_valid<=1.
//    Latency = 1 cycle after the stop-bit mid-sample.
//  - Handshake: pop when rx_valid & rx_ready; rx_valid falls the next cycle.
//    Byte done in the same cycle as a pop: load the new byte, rx_valid stays 1, no overrun.
//    Byte done while rx_valid=1 and no pop: overrun pulse; rx_data keeps the OLD byte;
//    the new byte is discarded.
//  - rx_ready is ignored when rx_valid=0.
//  - Timing tolerance: re-synchronisation happens only at the start edge, so the sampling
//    point stays within bit for +/-4% clock mismatch over 10 bits.
// STRUCTURE
//  - Package ook_pkg:
//      localparams OOK_DATA_BITS=8, OOK_IDLE_LEVEL=1'b0, OOK_START_LEVEL=1'b1;
//      FSM state encoding {IDLE, START, DATA, STOP, BREAK} (3 bits);
//      shared with the transmitter.
//  - Sub-module ook_rx_filter: synchroniser + majority filter, ports clk, rst, din, dout.
//    FSM, counter, shift register and holding register stay in the top.
// TESTING  (SAMPLES_PER_BIT=16, FILTER_TAPS=3, rx_ready=1 unless stated)
//  1 Send 0xA5 framed at 16 clk/bit -> rx_valid=1 for 1 cycle, rx_data=8'hA5,
//    frame_err=0, overrun=0.
//  2 1-cycle high glitch on ook_in in idle -> FSM stays IDLE, rx_busy never rises.
//  3 6-cycle high pulse (< half bit) -> START then IDLE. No rx_valid, no frame_err.
//  4 Frame 0x3C with stop bit held high for 40 cycles -> frame_err 1-cycle pulse,
//    no rx_valid, FSM in BREAK until line low, then IDLE.
//    A following 0x81 frame is received correctly.
//  5 rx_ready=0, send 0x11 then 0x22 back-to-back -> overrun pulse at the 2nd byte,
//    rx_data=8'h11, rx_valid=1. Assert rx_ready -> rx_valid=0 next cycle.
//  6 Assert rst for 1 cycle during D4 of a frame -> all outputs 0, IDLE.
//    Next full frame 0xF0 -> rx_data=8'hF0.

Source files
------------

// File: rtl/ook_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ook_pkg
//  Description : Shared OOK link definitions (frame levels, data width and
//                receiver/transmitter FSM state encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package ook_pkg;

    localparam int   OOK_DATA_BITS   = 8;
    localparam logic OOK_IDLE_LEVEL  = 1'b0;
    localparam logic OOK_START_LEVEL = 1'b1;

    localparam int OOK_STATE_W = 3;
    typedef logic [OOK_STATE_W-1:0] ook_state_t;

    localparam ook_state_t c_st_idle  = 3'd0;
    localparam ook_state_t c_st_start = 3'd1;
    localparam ook_state_t c_st_data  = 3'd2;
    localparam ook_state_t c_st_stop  = 3'd3;
    localparam ook_state_t c_st_break = 3'd4;

endpackage
`default_nettype wire

// File: rtl/ook_rx_filter.sv
`default_nettype none
// ============================================================================
//  Module      : ook_rx_filter
//  Description : Two-flop synchroniser for the asynchronous comparator pin
//                followed by a FILTER_TAPS-deep majority glitch filter.
//  Revision    : 1.0 - initial release
// ============================================================================
module ook_rx_filter #(
    parameter int FILTER_TAPS = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    // Majority threshold: more than half of the taps must be high.
    localparam logic [2:0] c_THRESH = 3'((FILTER_TAPS + 1) / 2);

    logic [1:0]             r_sync;
    logic [FILTER_TAPS-1:0] r_taps;
    logic [2:0]             w_ones;

    // Synchronise the pin, then shift the clean sample into the filter window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_taps <= '0;
        end else begin
            r_sync <= {r_sync[0], din};
            r_taps <= {r_taps[FILTER_TAPS-2:0], r_sync[1]};
        end
    end

    // Count high taps; the filtered line is their majority.
    always_comb begin
        w_ones = '0;
        for (int i = 0; i < FILTER_TAPS; i++) begin
            w_ones = w_ones + 3'(r_taps[i]);
        end
    end

    assign dout = (w_ones >= c_THRESH);

endmodule
`default_nettype wire

// File: rtl/ook_rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : ook_rx_deframer
//  Description : OOK optical link receiver. Filters the comparator pin,
//                detects the start bit, mid-bit samples 8 LSB-first data
//                bits, checks the stop bit and presents each byte on a
//                valid/ready holding register with overrun reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module ook_rx_deframer
    import ook_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = 64,
    parameter int FILTER_TAPS     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ook_in,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int c_CNT_W = $clog2(SAMPLES_PER_BIT);
    localparam int c_IDX_W = $clog2(OOK_DATA_BITS);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SAMPLES_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MID  = c_CNT_W'(SAMPLES_PER_BIT / 2 - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(OOK_DATA_BITS - 1);

    logic                     w_line;
    logic                     w_byte_done;
    ook_state_t               r_state;
    logic [c_CNT_W-1:0]       r_cnt;
    logic [c_IDX_W-1:0]       r_bit_idx;
    logic [OOK_DATA_BITS-1:0] r_shreg;
    logic                     r_frame_err;
    logic [OOK_DATA_BITS-1:0] r_data;
    logic                     r_valid;
    logic                     r_overrun;

    ook_rx_filter #(
        .FILTER_TAPS (FILTER_TAPS)
    ) u_filter (
        .clk  (clk),
        .rst  (rst),
        .din  (ook_in),
        .dout (w_line)
    );

    // Frame FSM: bit timing is anchored only at the start edge, then free-runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_cnt <= '0;
                    if (w_line == OOK_START_LEVEL) begin
                        r_state <= c_st_start;
                    end
                end
                c_st_start: begin
                    if (r_cnt == c_CNT_MID) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        // A start that has vanished by mid-bit was noise.
                        r_state   <= (w_line == OOK_START_LEVEL) ? c_st_data : c_st_idle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_data: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt              <= '0;
                        r_shreg[r_bit_idx] <= w_line;
                        r_bit_idx          <= r_bit_idx + 1'b1;
                        if (r_bit_idx == c_IDX_LAST) begin
                            r_state <= c_st_stop;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_stop: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt <= '0;
                        if (w_line == OOK_IDLE_LEVEL) begin
                            r_state <= c_st_idle;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= c_st_break;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_break: begin
                    // Light stuck on: do not re-arm until the line returns to idle.
                    r_cnt <= '0;
                    if (w_line == OOK_IDLE_LEVEL) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign w_byte_done = (r_state == c_st_stop) && (r_cnt == c_CNT_LAST) &&
                         (w_line == OOK_IDLE_LEVEL);

    // Holding register: a pop in the same cycle frees the slot for the new byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_byte_done) begin
                if (!r_valid || rx_ready) begin
                    r_data  <= r_shreg;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign rx_busy   = (r_state == c_st_start) || (r_state == c_st_data) ||
                       (r_state == c_st_stop);

endmodule
`default_nettype wire

// File: tb/tb_ook_rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ook_rx_deframer
//  Description : Self-checking bench for ook_rx_deframer. Frames are built
//                from bytes at the bit level; expectations come from the
//                frame rules (byte order, latency, handshake outcome).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ook_rx_deframer;

    localparam int SPB  = 16;
    localparam int TAPS = 3;
    // Cycles from the start edge on the pin to rx_valid / frame_err rising:
    // filter latency, one cycle to leave idle, half a bit to the start
    // mid-sample, then nine whole bits to the stop mid-sample.
    localparam int LAT  = 2 + (TAPS + 1) / 2 + 1 + SPB / 2 + 9 * SPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       ook_in;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    int   got_q[$];
    int   rise_q[$];
    int   ferr_q[$];
    int   n_valid_cyc = 0;
    int   n_ferr      = 0;
    int   n_ovr       = 0;
    int   n_busy      = 0;
    logic prev_valid  = 1'b0;

    ook_rx_deframer #(
        .SAMPLES_PER_BIT (SPB),
        .FILTER_TAPS     (TAPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ook_in    (ook_in),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    always #8 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs mid-cycle: accepted bytes, rise times, pulse counts.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && !prev_valid) rise_q.push_back(cyc);
            if (rx_valid) n_valid_cyc++;
            if (rx_valid && rx_ready) got_q.push_back(int'(rx_data));
            if (frame_err) begin
                n_ferr++;
                ferr_q.push_back(cyc);
            end
            if (overrun) n_ovr++;
            if (rx_busy) n_busy++;
        end
        prev_valid = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int idx);
        if (idx >= 0 && idx < q.size()) return q[idx];
        return 32'hDEAD;
    endfunction

    task automatic hold(input logic lvl, input int n);
        ook_in = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start bit, D0..D7 LSB first, stop bit. A non-zero stop_hi keeps the
    // light on for that many cycles from the start of the stop bit.
    task automatic send_frame(input logic [7:0] b, input int stop_hi, output int p0);
        p0 = cyc;
        hold(1'b1, SPB);
        for (int i = 0; i < 8; i++) hold(b[i], SPB);
        if (stop_hi > 0) hold(1'b1, stop_hi);
        hold(1'b0, SPB);
    endtask

    int         p0, p1, g0, v0, f0, o0, b0;
    logic [7:0] rb;
    int         exp_q[$];
    int         p0_q[$];

    initial begin
        rst      = 1'b1;
        ook_in   = 1'b0;
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rx_data",   32'(rx_data),   32'h0);
        check("reset_rx_valid",  32'(rx_valid),  32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_overrun",   32'(overrun),   32'h0);
        check("reset_rx_busy",   32'(rx_busy),   32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold(1'b0, 10);

        // Directed byte 0xA5.
        g0 = got_q.size(); v0 = n_valid_cyc; f0 = n_ferr; o0 = n_ovr;
        send_frame(8'hA5, 0, p0);
        hold(1'b0, SPB);
        check("a5_count",     32'(got_q.size() - g0),   32'd1);
        check("a5_data",      32'(qget(got_q, g0)),     32'hA5);
        check("a5_latency",   32'(rise_q[$] - p0),      32'(LAT));
        check("a5_valid_len", 32'(n_valid_cyc - v0),    32'd1);
        check("a5_ferr",      32'(n_ferr - f0),         32'd0);
        check("a5_ovr",       32'(n_ovr - o0),          32'd0);

        // Random bytes with random idle gaps (including back-to-back).
        g0 = got_q.size(); f0 = n_ferr;
        exp_q.delete(); p0_q.delete();
        for (int k = 0; k < 6; k++) begin
            rb = 8'($urandom);
            send_frame(rb, 0, p1);
            exp_q.push_back(int'(rb));
            p0_q.push_back(p1);
            hold(1'b0, $urandom_range(0, 20));
        end
        hold(1'b0, SPB);
        check("rnd_count", 32'(got_q.size() - g0), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            check("rnd_data", 32'(qget(got_q, g0 + k)), 32'(exp_q[k]));
            check("rnd_latency",
                  32'(qget(rise_q, rise_q.size() - exp_q.size() + k) - p0_q[k]),
                  32'(LAT));
        end
        check("rnd_ferr", 32'(n_ferr - f0), 32'd0);

        // Single-cycle glitches never leave idle.
        b0 = n_busy; g0 = got_q.size();
        for (int k = 0; k < 4; k++) begin
            hold(1'b1, 1);
            hold(1'b0, $urandom_range(3, 12));
        end
        hold(1'b0, SPB);
        check("glitch_busy",  32'(n_busy - b0),        32'd0);
        check("glitch_bytes", 32'(got_q.size() - g0),  32'd0);

        // Short pulse: false start, busy for exactly half a bit.
        b0 = n_busy; g0 = got_q.size(); f0 = n_ferr;
        hold(1'b1, 6);
        hold(1'b0, 3 * SPB);
        check("short_busy",  32'(n_busy - b0),       32'(SPB / 2));
        check("short_bytes", 32'(got_q.size() - g0), 32'd0);
        check("short_ferr",  32'(n_ferr - f0),       32'd0);

        // Stop bit stuck high: frame error, no byte, no re-trigger.
        b0 = n_busy; g0 = got_q.size(); f0 = n_ferr;
        send_frame(8'h3C, 40, p0);
        hold(1'b0, SPB);
        check("brk_ferr_len",  32'(n_ferr - f0),       32'd1);
        check("brk_ferr_time", 32'(ferr_q[$] - p0),    32'(LAT));
        check("brk_busy",      32'(n_busy - b0),       32'(SPB / 2 + 9 * SPB));
        check("brk_bytes",     32'(got_q.size() - g0), 32'd0);
        g0 = got_q.size();
        send_frame(8'h81, 0, p0);
        hold(1'b0, SPB);
        check("after_brk_data", 32'(qget(got_q, g0)), 32'h81);

        // Overrun: second byte dropped while the first is held.
        rx_ready = 1'b0;
        g0 = got_q.size(); o0 = n_ovr;
        send_frame(8'h11, 0, p0);
        send_frame(8'h22, 0, p1);
        hold(1'b0, SPB);
        @(negedge clk);
        check("ovr_pulses",  32'(n_ovr - o0),  32'd1);
        check("ovr_valid",   32'(rx_valid),    32'h1);
        check("ovr_data",    32'(rx_data),     32'h11);
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("pop_valid_low", 32'(rx_valid),            32'h0);
        check("ovr_pop_count", 32'(got_q.size() - g0),   32'd1);
        check("ovr_pop_data",  32'(qget(got_q, g0)),     32'h11);

        // Byte completes in the very cycle the held byte is popped.
        rx_ready = 1'b0;
        g0 = got_q.size(); o0 = n_ovr;
        send_frame(8'h5A, 0, p0);
        hold(1'b0, 4);
        fork
            send_frame(8'h6B, 0, p1);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1;
                rx_ready = 1'b1;
            end
        join
        hold(1'b0, SPB);
        check("coinc_count", 32'(got_q.size() - g0),   32'd2);
        check("coinc_old",   32'(qget(got_q, g0)),     32'h5A);
        check("coinc_new",   32'(qget(got_q, g0 + 1)), 32'h6B);
        check("coinc_ovr",   32'(n_ovr - o0),          32'd0);

        // Reset during D4 discards both the held byte and the partial frame.
        rx_ready = 1'b0;
        send_frame(8'h77, 0, p0);
        hold(1'b0, 4);
        rb = 8'($urandom) & 8'h0F;
        fork
            send_frame(rb, 0, p1);
            begin
                repeat (5 * SPB + SPB / 2) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                check("rst_rx_valid",  32'(rx_valid),  32'h0);
                check("rst_rx_data",   32'(rx_data),   32'h0);
                check("rst_rx_busy",   32'(rx_busy),   32'h0);
                check("rst_frame_err", 32'(frame_err), 32'h0);
                check("rst_overrun",   32'(overrun),   32'h0);
            end
        join
        hold(1'b0, 2 * SPB);
        g0 = got_q.size();
        rx_ready = 1'b1;
        check("rst_no_valid", 32'(rx_valid), 32'h0);
        send_frame(8'hF0, 0, p0);
        hold(1'b0, SPB);
        check("f0_count",   32'(got_q.size() - g0), 32'd1);
        check("f0_data",    32'(qget(got_q, g0)),   32'hF0);
        check("f0_latency", 32'(rise_q[$] - p0),    32'(LAT));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
